// File: rtl/i2c_apb_cmd_sequencer_if.sv
// Command, response and APB bundle between the I2C APB command sequencer and its neighbours.
// master is the sequencer side; slave is the command source / APB target side.
interface i2c_apb_cmd_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic          cmd_poll;
    logic [7:0]    cmd_addr;
    logic [7:0]    cmd_data;
    logic [7:0]    cmd_match;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_data;
    logic          rsp_err;
    logic [7:0]    apb_addr;
    logic          apb_sel;
    logic          apb_ena;
    logic          apb_write;
    logic [7:0]    apb_wdata;
    logic [7:0]    apb_rdata;
    logic          apb_rready;
    logic          busy;
    logic [LW-1:0] fifo_level;

    modport master (
        input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_data, cmd_match,
        input  rsp_ready, apb_rdata, apb_rready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output apb_addr, apb_sel, apb_ena, apb_write, apb_wdata, busy, fifo_level
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_data, cmd_match,
        output rsp_ready, apb_rdata, apb_rready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  apb_addr, apb_sel, apb_ena, apb_write, apb_wdata, busy, fifo_level
    );
endinterface

// File: rtl/i2c_apb_cmd_sequencer.sv
// APB master that drains a small command FIFO of write / read / poll-until-match accesses
// to the I2C controller register port and returns one response per command, in order.
module i2c_apb_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_MAX   = 256,
    parameter int unsigned POLL_GAP   = 16
) (
    input logic                     wb_clk_i,
    input logic                     wb_rst_i,
    i2c_apb_cmd_sequencer_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned AW = $clog2(POLL_MAX + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);

    typedef struct packed {
        logic       write;
        logic       poll;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] match;
    } cmd_t;

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StGap, StResp} state_t;

    cmd_t          fifo_mem [FIFO_DEPTH];
    cmd_t          head;
    cmd_t          cmd_in;
    cmd_t          cmd_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    state_t        state_q;
    logic [AW-1:0] attempt_q;
    logic [GW-1:0] gap_q;
    logic          push, pop, poll_hit;
    logic          rsp_valid_q, rsp_err_q;
    logic [7:0]    rsp_data_q;
    logic          sel_q, ena_q, write_q;
    logic [7:0]    addr_q, wdata_q;

    assign cmd_in   = '{write: bus.cmd_write, poll: bus.cmd_poll, addr: bus.cmd_addr,
                        data: bus.cmd_data, match: bus.cmd_match};
    assign head     = fifo_mem[rd_ptr_q];
    // Held low during reset so every output reads 0 while wb_rst_i is high.
    assign bus.cmd_ready = !wb_rst_i && (level_q < LW'(FIFO_DEPTH));
    assign push     = bus.cmd_valid && bus.cmd_ready;
    assign pop      = (state_q == StIdle) && (level_q != '0) && !rsp_valid_q;
    assign poll_hit = (bus.apb_rdata & cmd_q.data) == cmd_q.match;

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            attempt_q   <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            sel_q       <= 1'b0;
            ena_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        cmd_q     <= head;
                        attempt_q <= '0;
                        sel_q     <= 1'b1;
                        addr_q    <= head.addr;
                        write_q   <= head.write && !head.poll;
                        wdata_q   <= head.data;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    ena_q   <= 1'b1;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (bus.apb_rready) begin
                        sel_q   <= 1'b0;
                        ena_q   <= 1'b0;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        if (cmd_q.poll) begin
                            attempt_q  <= attempt_q + AW'(1);
                            rsp_data_q <= bus.apb_rdata;
                            if (poll_hit || attempt_q == AW'(POLL_MAX - 1)) begin
                                rsp_err_q   <= !poll_hit;
                                rsp_valid_q <= 1'b1;
                                state_q     <= StResp;
                            end else begin
                                gap_q   <= '0;
                                state_q <= StGap;
                            end
                        end else begin
                            rsp_data_q  <= cmd_q.write ? 8'h00 : bus.apb_rdata;
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StGap: begin
                    if (gap_q == GW'(POLL_GAP - 1)) begin
                        sel_q   <= 1'b1;
                        addr_q  <= cmd_q.addr;
                        wdata_q <= cmd_q.data;
                        state_q <= StSetup;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.apb_addr   = addr_q;
    assign bus.apb_sel    = sel_q;
    assign bus.apb_ena    = ena_q;
    assign bus.apb_write  = write_q;
    assign bus.apb_wdata  = wdata_q;
    assign bus.busy       = (state_q != StIdle) || (level_q != '0);
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_i2c_apb_cmd_sequencer.sv
// Directed bench for the I2C APB command sequencer: write, wait-stated read, matching and
// timing-out polls, FIFO full back-pressure with ordered responses, and reset mid-access.
module tb_i2c_apb_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       echo;
    logic [7:0] rdata_drv;
    int         n_checks = 0;
    int         n_pass = 0;
    int         reads;

    always #5 clk = ~clk;

    i2c_apb_cmd_sequencer_if #(.FIFO_DEPTH(4)) bus ();

    i2c_apb_cmd_sequencer #(
        .FIFO_DEPTH(4),
        .POLL_MAX  (4),
        .POLL_GAP  (16)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    // Echo mode gives each address a distinct read value so response order is visible.
    assign bus.apb_rdata = echo ? (bus.apb_addr ^ 8'h5A) : rdata_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic wr, input logic pl, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] m);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_poll  = pl;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_match = m;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic accept();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic take_rsp(input string tag, input logic [7:0] d, input logic e);
        int t = 0;
        while (!bus.rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, bus.rsp_valid, 1);
        check({tag, "_data"}, bus.rsp_data, d);
        check({tag, "_err"}, bus.rsp_err, e);
        accept();
    endtask

    // Follows a poll command; ramp=1 returns 0x10+2k on read k, else 0x00 until read 4 gives 0x01.
    task automatic run_poll(input bit ramp, output int n_reads);
        int gap = 0;
        int t = 0;
        n_reads = 0;
        while (t < 500) begin
            @(negedge clk);
            t++;
            if (bus.rsp_valid) break;
            if (bus.apb_sel) begin
                if (!bus.apb_ena && gap != 0) check("poll_gap", gap, 16);
                gap = 0;
                if (bus.apb_ena) begin
                    n_reads++;
                    if (ramp) rdata_drv = 8'(8'h10 + 2 * n_reads);
                    else      rdata_drv = (n_reads >= 4) ? 8'h01 : 8'h00;
                end
            end else begin
                gap++;
            end
        end
        check("poll_done", bus.rsp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_poll   = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_data   = '0;
        bus.cmd_match  = '0;
        bus.rsp_ready  = 1'b0;
        bus.apb_rready = 1'b1;
        echo           = 1'b0;
        rdata_drv      = '0;

        repeat (2) @(negedge clk);
        check("rst_sel", bus.apb_sel, 0);
        check("rst_ena", bus.apb_ena, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        rst = 1'b0;
        #1 check("post_rst_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);

        // Write with zero wait states
        push(1'b1, 1'b0, 8'h04, 8'hA5, 8'h00);
        check("wr_level", bus.fifo_level, 1);
        check("wr_idle_sel", bus.apb_sel, 0);
        @(negedge clk);
        check("wr_setup_sel", bus.apb_sel, 1);
        check("wr_setup_ena", bus.apb_ena, 0);
        check("wr_setup_addr", bus.apb_addr, 8'h04);
        check("wr_setup_write", bus.apb_write, 1);
        check("wr_setup_wdata", bus.apb_wdata, 8'hA5);
        @(negedge clk);
        check("wr_access_sel", bus.apb_sel, 1);
        check("wr_access_ena", bus.apb_ena, 1);
        check("wr_access_wdata", bus.apb_wdata, 8'hA5);
        @(negedge clk);
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_data", bus.rsp_data, 8'h00);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rsp_sel", bus.apb_sel, 0);
        accept();
        check("wr_after_valid", bus.rsp_valid, 0);
        check("wr_after_busy", bus.busy, 0);

        // Read with five wait states
        bus.apb_rready = 1'b0;
        rdata_drv      = 8'h3C;
        push(1'b0, 1'b0, 8'h08, 8'h00, 8'h00);
        @(negedge clk);
        check("rd_setup_sel", bus.apb_sel, 1);
        check("rd_setup_write", bus.apb_write, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rd_wait_ena", bus.apb_ena, 1);
            check("rd_wait_addr", bus.apb_addr, 8'h08);
            if (i == 5) bus.apb_rready = 1'b1;
        end
        @(negedge clk);
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_data", bus.rsp_data, 8'h3C);
        check("rd_rsp_ena", bus.apb_ena, 0);
        accept();

        // Poll that matches on the fourth read
        rdata_drv = 8'h00;
        push(1'b0, 1'b1, 8'h0C, 8'h01, 8'h01);
        run_poll(1'b0, reads);
        check("poll_match_reads", reads, 4);
        take_rsp("poll_match", 8'h01, 1'b0);

        // Poll that never matches: POLL_MAX=4 reads then timeout
        push(1'b0, 1'b1, 8'h0C, 8'hFF, 8'h5A);
        run_poll(1'b1, reads);
        check("poll_to_reads", reads, 4);
        take_rsp("poll_to", 8'h18, 1'b1);

        // Fill the FIFO while the first response is held
        echo = 1'b1;
        for (int k = 0; k < 5; k++) push(1'b0, 1'b0, 8'(8'h30 + k), 8'h00, 8'h00);
        check("full_level", bus.fifo_level, 4);
        check("full_cmd_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 8'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_no_apb", bus.apb_sel, 0);
            check("full_level_hold", bus.fifo_level, 4);
            check("full_rsp_hold", bus.rsp_data, 8'h6A);
        end
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) take_rsp("order", 8'((8'h30 + k) ^ 8'h5A), 1'b0);
        check("drain_level", bus.fifo_level, 0);
        check("drain_busy", bus.busy, 0);
        echo = 1'b0;

        // Reset in the middle of an ACCESS wait
        bus.apb_rready = 1'b0;
        push(1'b0, 1'b0, 8'h50, 8'h00, 8'h00);
        push(1'b0, 1'b0, 8'h54, 8'h00, 8'h00);
        @(negedge clk);
        check("mid_ena", bus.apb_ena, 1);
        check("mid_level", bus.fifo_level, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_sel", bus.apb_sel, 0);
        check("arst_ena", bus.apb_ena, 0);
        check("arst_level", bus.fifo_level, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_busy", bus.busy, 0);
        @(negedge clk);
        rst            = 1'b0;
        bus.apb_rready = 1'b1;
        repeat (3) @(negedge clk);
        check("rel_cmd_ready", bus.cmd_ready, 1);
        check("rel_sel", bus.apb_sel, 0);
        check("rel_rsp_valid", bus.rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
